// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: the pipeline MEM stage owns the port by default, a DMA requester is
// served in idle cycles or, after STARVE_LIMIT unserved cycles, in a forced one-cycle stall slot.
module dmem_arbiter #(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p_rd,
   input  logic              p_wr,
   input  logic [ADDR_W-1:0] p_addr,
   input  logic [DATA_W-1:0] p_wdata,
   output logic [DATA_W-1:0] p_rdata,
   output logic              p_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_re,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FORCE = 2'd1;
   localparam logic [1:0] ACK   = 2'd2;

   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

   logic [1:0]        state_q, state_d;
   logic [7:0]        wait_cnt_q, wait_cnt_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              p_req;
   logic              p_own;
   logic              d_own;

   assign p_req = p_rd | p_wr;

   always_comb begin
      p_own      = 1'b0;
      d_own      = 1'b0;
      state_d    = state_q;
      wait_cnt_d = 8'd0;
      case (state_q)
         IDLE: begin
            p_own = p_req;
            d_own = ~p_req & d_req;
            if (d_own) begin
               state_d = ACK;
            end else if (d_req) begin
               if (wait_cnt_q == LIMIT - 8'd1) begin
                  state_d = FORCE;
               end
               wait_cnt_d = (wait_cnt_q >= LIMIT) ? LIMIT : wait_cnt_q + 8'd1;
            end
         end
         FORCE: begin
            d_own   = 1'b1;
            state_d = ACK;
         end
         ACK: begin
            p_own   = p_req;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Reset kills any ownership immediately so an in-flight write never lands.
      if (!reset) begin
         p_own = 1'b0;
         d_own = 1'b0;
      end
   end

   assign d_rdata_d = d_own ? mem_rdata : d_rdata_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         wait_cnt_q <= 8'd0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      if (p_own) begin
         mem_addr  = p_addr;
         mem_wdata = p_wdata;
         mem_we    = p_wr;
         mem_re    = p_rd & ~p_wr;
      end else if (d_own) begin
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
         mem_we    = d_we;
         mem_re    = ~d_we;
      end
   end

   assign p_rdata = p_own ? mem_rdata : '0;
   assign p_stall = reset & (state_q == FORCE);
   assign d_ack   = (state_q == ACK);
   assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table for single-cycle behaviour plus hand-written
// sequences for starvation, forced-slot blocking, counter clear and reset during FORCE.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        p_rd, p_wr, d_req, d_we;
   logic [31:0] p_addr, p_wdata, d_addr, d_wdata;
   logic [31:0] p_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        p_stall, d_ack, mem_re, mem_we;

   int n_vec = 0;
   int n_err = 0;

   // Memory model: preloaded contents until a location is first written.
   logic [31:0] mem [0:255];
   logic [255:0] written = '0;

   function automatic logic [31:0] init_val(input logic [7:0] a);
      case (a)
         8'h10:   return 32'hDEADBEEF;
         8'h30:   return 32'h0000AAAA;
         8'h40:   return 32'h12345678;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] mem_val(input logic [7:0] a);
      return written[a] ? mem[a] : init_val(a);
   endfunction

   assign mem_rdata = (mem_addr[31:8] != 24'h0) ? 32'hBADBAD00 : mem_val(mem_addr[7:0]);

   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr[7:0]]     <= mem_wdata;
         written[mem_addr[7:0]] <= 1'b1;
      end
   end

   always #5 clk = ~clk;

   dmem_arbiter #(
      .DATA_W      (32),
      .ADDR_W      (32),
      .STARVE_LIMIT(8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .p_rd     (p_rd),
      .p_wr     (p_wr),
      .p_addr   (p_addr),
      .p_wdata  (p_wdata),
      .p_rdata  (p_rdata),
      .p_stall  (p_stall),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_ack    (d_ack),
      .d_rdata  (d_rdata),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_re   (mem_re),
      .mem_we   (mem_we),
      .mem_rdata(mem_rdata)
   );

   typedef struct {
      logic        rst, prd, pwr;
      logic [31:0] paddr, pwdata;
      logic        dreq, dwe;
      logic [31:0] daddr, dwdata;
      logic        e_stall, e_ack, e_re, e_we;
      logic [31:0] e_addr, e_prdata, e_drdata;
   } vec_t;

   function automatic vec_t mk(input logic rst, prd, pwr, input logic [31:0] paddr, pwdata,
                               input logic dreq, dwe, input logic [31:0] daddr, dwdata,
                               input logic e_stall, e_ack, e_re, e_we,
                               input logic [31:0] e_addr, e_prdata, e_drdata);
      vec_t v;
      v.rst = rst; v.prd = prd; v.pwr = pwr; v.paddr = paddr; v.pwdata = pwdata;
      v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwdata = dwdata;
      v.e_stall = e_stall; v.e_ack = e_ack; v.e_re = e_re; v.e_we = e_we;
      v.e_addr = e_addr; v.e_prdata = e_prdata; v.e_drdata = e_drdata;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic prd, pwr, input logic [31:0] paddr, pwdata,
                        input logic dreq, dwe, input logic [31:0] daddr, dwdata);
      p_rd = prd; p_wr = pwr; p_addr = paddr; p_wdata = pwdata;
      d_req = dreq; d_we = dwe; d_addr = daddr; d_wdata = dwdata;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   vec_t vecs [13];

   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;

      //           rst prd pwr paddr  pwdata        dreq dwe daddr  dwdata
      //           stall ack re we addr    p_rdata       d_rdata
      vecs[0]  = mk(0, 1, 0, 32'h40, 0,            0, 0, 0,     0,
                    0, 0, 0, 0, 32'h0,  32'h0,        32'h0);
      vecs[1]  = mk(1, 0, 0, 0,      0,            0, 0, 0,     0,
                    0, 0, 0, 0, 32'h0,  32'h0,        32'h0);
      vecs[2]  = mk(1, 0, 0, 0,      0,            1, 0, 32'h10, 0,
                    0, 0, 1, 0, 32'h10, 32'h0,        32'h0);
      vecs[3]  = mk(1, 0, 0, 0,      0,            0, 0, 0,     0,
                    0, 1, 0, 0, 32'h0,  32'h0,        32'hDEADBEEF);
      vecs[4]  = mk(1, 1, 0, 32'h40, 0,            0, 0, 0,     0,
                    0, 0, 1, 0, 32'h40, 32'h12345678, 32'hDEADBEEF);
      vecs[5]  = mk(1, 1, 1, 32'h44, 32'hCAFE0001, 0, 0, 0,     0,
                    0, 0, 0, 1, 32'h44, 32'h0,        32'hDEADBEEF);
      vecs[6]  = mk(1, 1, 0, 32'h44, 0,            0, 0, 0,     0,
                    0, 0, 1, 0, 32'h44, 32'hCAFE0001, 32'hDEADBEEF);
      vecs[7]  = mk(1, 1, 0, 32'h40, 0,            1, 1, 32'h48, 32'h77,
                    0, 0, 1, 0, 32'h40, 32'h12345678, 32'hDEADBEEF);
      vecs[8]  = mk(1, 0, 0, 0,      0,            1, 1, 32'h48, 32'h77,
                    0, 0, 0, 1, 32'h48, 32'h0,        32'hDEADBEEF);
      vecs[9]  = mk(1, 0, 1, 32'h4C, 32'h5,        0, 0, 0,     0,
                    0, 1, 0, 1, 32'h4C, 32'h0,        32'h0);
      vecs[10] = mk(1, 0, 0, 0,      0,            1, 0, 32'h48, 0,
                    0, 0, 1, 0, 32'h48, 32'h0,        32'h0);
      vecs[11] = mk(1, 0, 0, 0,      0,            0, 0, 0,     0,
                    0, 1, 0, 0, 32'h0,  32'h0,        32'h77);
      vecs[12] = mk(1, 0, 0, 0,      0,            0, 0, 0,     0,
                    0, 0, 0, 0, 32'h0,  32'h0,        32'h77);

      for (int i = 0; i < 13; i++) begin
         reset = vecs[i].rst;
         drive(vecs[i].prd, vecs[i].pwr, vecs[i].paddr, vecs[i].pwdata,
               vecs[i].dreq, vecs[i].dwe, vecs[i].daddr, vecs[i].dwdata);
         @(negedge clk);
         chk($sformatf("v%0d p_stall", i), 32'(p_stall), 32'(vecs[i].e_stall));
         chk($sformatf("v%0d d_ack", i),   32'(d_ack),   32'(vecs[i].e_ack));
         chk($sformatf("v%0d mem_re", i),  32'(mem_re),  32'(vecs[i].e_re));
         chk($sformatf("v%0d mem_we", i),  32'(mem_we),  32'(vecs[i].e_we));
         chk($sformatf("v%0d mem_addr", i), mem_addr,    vecs[i].e_addr);
         chk($sformatf("v%0d p_rdata", i), p_rdata,      vecs[i].e_prdata);
         chk($sformatf("v%0d d_rdata", i), d_rdata,      vecs[i].e_drdata);
         next_cycle();
      end
      chk("mem[44]", mem_val(8'h44), 32'hCAFE0001);
      chk("mem[48]", mem_val(8'h48), 32'h77);
      chk("mem[4C]", mem_val(8'h4C), 32'h5);

      // Starvation: continuous pipeline reads, DMA write forced in at cycle 8, acked at 9.
      for (int c = 0; c < 12; c++) begin
         drive(1, 0, 32'h40, 0, c < 9, 1, 32'h20, 32'h55);
         @(negedge clk);
         chk($sformatf("starve c%0d p_stall", c), 32'(p_stall), 32'(c == 8));
         chk($sformatf("starve c%0d mem_we", c),  32'(mem_we),  32'(c == 8));
         chk($sformatf("starve c%0d d_ack", c),   32'(d_ack),   32'(c == 9));
         chk($sformatf("starve c%0d mem_addr", c), mem_addr, (c == 8) ? 32'h20 : 32'h40);
         next_cycle();
      end
      chk("starve mem[20]", mem_val(8'h20), 32'h55);

      // Forced slot blocks a pipeline write; the write lands once reissued in ACK.
      for (int c = 0; c < 11; c++) begin
         if (c < 8)       drive(1, 0, 32'h40, 0, 1, 0, 32'h10, 0);
         else if (c < 10) drive(0, 1, 32'h30, 32'h1, c == 8, 0, 32'h10, 0);
         else             drive(0, 0, 0, 0, 0, 0, 0, 0);
         @(negedge clk);
         chk($sformatf("block c%0d p_stall", c), 32'(p_stall), 32'(c == 8));
         if (c == 8) begin
            chk("block force mem_we", 32'(mem_we), 32'h0);
            chk("block force mem_addr", mem_addr, 32'h10);
         end
         if (c == 9) begin
            chk("block mem[30] after force", mem_val(8'h30), 32'h0000AAAA);
            chk("block ack d_rdata", d_rdata, 32'hDEADBEEF);
            chk("block ack mem_we", 32'(mem_we), 32'h1);
         end
         if (c == 10) chk("block mem[30] after ack", mem_val(8'h30), 32'h1);
         next_cycle();
      end

      // Counter clear: a one-cycle gap in d_req restarts the full wait.
      for (int c = 0; c < 17; c++) begin
         drive(1, 0, 32'h40, 0, (c < 5) || (c >= 6 && c < 15), 0, 32'h10, 0);
         @(negedge clk);
         chk($sformatf("clear c%0d p_stall", c), 32'(p_stall), 32'(c == 14));
         chk($sformatf("clear c%0d d_ack", c),   32'(d_ack),   32'(c == 15));
         next_cycle();
      end

      // Reset asserted during FORCE.
      for (int c = 0; c < 9; c++) begin
         drive(1, 0, 32'h40, 0, 1, 1, 32'h54, 32'h99);
         @(negedge clk);
         if (c < 8) next_cycle();
      end
      chk("rst pre p_stall", 32'(p_stall), 32'h1);
      chk("rst pre mem_we", 32'(mem_we), 32'h1);
      reset = 1'b0;
      #1;
      chk("rst mem_we", 32'(mem_we), 32'h0);
      chk("rst p_stall", 32'(p_stall), 32'h0);
      chk("rst mem_re", 32'(mem_re), 32'h0);
      chk("rst d_rdata", d_rdata, 32'h0);
      next_cycle();
      reset = 1'b1;
      drive(1, 0, 32'h40, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("post d_ack", 32'(d_ack), 32'h0);
      chk("post d_rdata", d_rdata, 32'h0);
      chk("post p_stall", 32'(p_stall), 32'h0);
      chk("post p_rdata", p_rdata, 32'h12345678);
      chk("post mem[54]", mem_val(8'h54), 32'h0);
      next_cycle();
      @(negedge clk);
      chk("post2 d_ack", 32'(d_ack), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single data-memory port between the pipeline MEM stage and a secondary loader/debug requester (DMA port). The pipeline owns memory by default, and the DMA port is served in idle cycles. A starvation counter forces a DMA slot by stalling the pipeline for one cycle. The block sits between the EX/MEM register outputs and the data memory, and feeds a stall term into the pipeline hazard logic.

## Interface
Parameters:
- `DATA_W`, 32, data width
- `ADDR_W`, 32, address width
- `STARVE_LIMIT`, 8, number of consecutive unserved DMA-request cycles before a forced slot; legal range 1..255

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted when 0)
- `p_rd`  in  1  pipeline MEM-stage read request
- `p_wr`  in  1  pipeline MEM-stage write request
- `p_addr`  in  ADDR_W  pipeline address
- `p_wdata`  in  DATA_W  pipeline write data
- `p_rdata`  out  DATA_W  pipeline read data (combinational from `mem_rdata`)
- `p_stall`  out  1  stall MEM stage this cycle (Moore output)
- `d_req`  in  1  DMA request; held with stable fields until `d_ack`
- `d_we`  in  1  DMA write (1) / read (0)
- `d_addr`  in  ADDR_W  DMA address
- `d_wdata`  in  DATA_W  DMA write data
- `d_ack`  out  1  one-cycle completion pulse (registered)
- `d_rdata`  out  DATA_W  registered DMA read data, valid while `d_ack`=1
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_re`  out  1  memory read enable
- `mem_we`  out  1  memory write enable (memory writes on `clk` edge)
- `mem_rdata`  in  DATA_W  memory read data, combinational from `mem_addr`

## Operation
- FSM states: IDLE, FORCE, ACK. Registered `wait_cnt`, 8 bits.
- Memory ownership in each state:
  - IDLE: pipeline owns the port if `p_rd|p_wr`. Otherwise DMA owns it if `d_req`. Otherwise no owner, and `mem_re`=`mem_we`=0.
  - FORCE: DMA owns the port and `p_stall`=1. Pipeline requests are ignored; no pipeline write reaches memory.
  - ACK: `d_ack`=1. DMA is never served in ACK. Pipeline owns the port if it requests.
- Transitions:
  - IDLE -> ACK when DMA is served in IDLE.
  - IDLE -> FORCE when `d_req`=1, DMA is not served, and `wait_cnt`==STARVE_LIMIT-1.
  - FORCE -> ACK, unconditionally.
  - ACK -> IDLE, unconditionally.
- `wait_cnt` update rules:
  - Increments in IDLE when `d_req`=1 and DMA is not served.
  - Clears on any DMA service, when `d_req`=0, and in FORCE/ACK.
  - Saturates at STARVE_LIMIT.
- On any DMA service, `d_rdata` <= `mem_rdata`, and it is held until the next service. For DMA writes, `d_rdata` loads the pre-write memory value.
- If `p_rd` and `p_wr` are both asserted, the request is treated as a write; `mem_re`=0.
- `p_rdata` = `mem_rdata` whenever the pipeline owns the port; otherwise 0.
- While `reset`=0:
  - State is forced to IDLE; `wait_cnt`, `d_ack` and `d_rdata` are 0.
  - `mem_we`, `mem_re` and `p_stall` are forced to 0 combinationally, so an in-flight write is suppressed.

## Timing
- Reset values: `p_stall`=0, `d_ack`=0, `d_rdata`=0, `mem_we`=0, `mem_re`=0, `mem_addr`=0, `mem_wdata`=0, `p_rdata`=0.
- Pipeline access has zero added latency: address and data pass through combinationally in the owning cycle.
- Idle-slot DMA latency: served in cycle N; `d_ack`=1 and `d_rdata` valid in cycle N+1.
- Worst-case DMA latency under continuous pipeline traffic is STARVE_LIMIT+2 cycles from `d_req` rising to `d_ack`:
  - STARVE_LIMIT wait cycles;
  - FORCE at cycle STARVE_LIMIT;
  - `d_ack` at cycle STARVE_LIMIT+1.
- `p_stall` is high for exactly one cycle per forced slot, and never in two consecutive cycles.
- DMA must drop or change its request in the `d_ack` cycle. Back-to-back DMA requests are separated by at least one non-DMA cycle (ACK).
- Reset released mid-FORCE or mid-ACK: first post-reset cycle is IDLE, with no `d_ack` pulse.

## Test plan
- Idle DMA read: pipeline idle, memory[0x10]=0xDEADBEEF, DMA reads 0x10. Required: `mem_re`=1 at cycle 0; `d_ack`=1 and `d_rdata`=0xDEADBEEF at cycle 1; `p_stall`=0 throughout.
- Starvation force: `p_rd`=1 every cycle, STARVE_LIMIT=8, DMA writes 0x55 to addr 0x20. Required:
  - `p_stall`=1 only at cycle 8, when `mem_we`=1 and `mem_addr`=0x20;
  - `d_ack` at cycle 9;
  - memory[0x20]=0x55.
- Forced slot blocks pipeline write: `p_wr`=1 to 0x30 with data 0x1 during FORCE. Required: memory[0x30] unchanged and `p_stall`=1. Once the pipeline reissues the write in ACK, memory[0x30]=0x1.
- Counter clear: `d_req` high for 5 cycles under pipeline traffic, low for 1 cycle, then high again. Required: no FORCE until 8 further unserved cycles.
- Simultaneous requests in IDLE: `p_rd` and `d_req` both rise in the same cycle. Required: pipeline served with `p_stall`=0; DMA waits and `wait_cnt`=1.
- Reset mid-operation: assert `reset`=0 during FORCE. Required:
  - `mem_we`=0 and `p_stall`=0 immediately;
  - after release, state is IDLE, `d_ack` stays 0, and `d_rdata`=0.
